// File: rtl/axi4_lite_pkg.sv
// Shared constants, FSM encodings and the byte-lane merge helper for the
// AXI4-Lite register file.
package axi4_lite_pkg;

    localparam logic [1:0]  RESP_OKAY        = 2'b00;
    localparam logic [1:0]  RESP_SLVERR      = 2'b10;
    localparam logic [31:0] DEFAULT_ID_VALUE = 32'hA11E_0001;

    typedef enum logic {
        W_IDLE = 1'b0,
        W_RESP = 1'b1
    } w_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } r_state_t;

    function automatic logic [31:0] apply_strobe(
        input logic [31:0] old_word,
        input logic [31:0] new_word,
        input logic [3:0]  strb
    );
        logic [31:0] merged;
        merged = old_word;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) begin
                merged[8*b +: 8] = new_word[8*b +: 8];
            end else begin
                merged[8*b +: 8] = old_word[8*b +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/axi4_lite_reg_bank.sv
// Register storage: byte-strobed write port and a registered read port that
// also serves the read-only ID word and the out-of-range zero.
module axi4_lite_reg_bank
    import axi4_lite_pkg::*;
#(
    parameter int          NUM_REGS = 16,
    parameter logic [31:0] ID_VALUE = DEFAULT_ID_VALUE,
    parameter int          IDX_W    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  logic [31:0]      wdata,
    input  logic [3:0]       wstrb,
    input  logic             re,
    input  logic             raddr_ok,
    input  logic [IDX_W-1:0] raddr,
    output logic [31:0]      rdata
);

    localparam logic [IDX_W:0] LAST_IDX = (IDX_W + 1)'(NUM_REGS - 1);

    logic [31:0] mem_r [NUM_REGS-1];
    logic [31:0] rdata_r;

    // Writable registers; the ID slot has no storage.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS - 1; i++) begin
                mem_r[i] <= 32'h0000_0000;
            end
        end else if (we && ({1'b0, waddr} < LAST_IDX)) begin
            mem_r[waddr] <= apply_strobe(mem_r[waddr], wdata, wstrb);
        end
    end

    // Read data is captured only on the address handshake so it holds while the master stalls.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_r <= 32'h0000_0000;
        end else if (re) begin
            if (!raddr_ok) begin
                rdata_r <= 32'h0000_0000;
            end else if ({1'b0, raddr} == LAST_IDX) begin
                rdata_r <= ID_VALUE;
            end else begin
                rdata_r <= mem_r[raddr];
            end
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/axi4_lite_register_file.sv
// AXI4-Lite slave front end: independent write and read handshake FSMs in
// front of a register bank whose last word is a read-only ID.
module axi4_lite_register_file
    import axi4_lite_pkg::*;
#(
    parameter int          NUM_REGS = 16,
    parameter logic [31:0] ID_VALUE = DEFAULT_ID_VALUE
) (
    input  logic        aclk,
    input  logic        areset,
    input  logic [31:0] awaddr,
    input  logic [2:0]  awprot,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wvalid,
    output logic        wready,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready,
    input  logic [31:0] araddr,
    input  logic [2:0]  arprot,
    input  logic        arvalid,
    output logic        arready,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rvalid,
    input  logic        rready
);

    localparam int             IDX_W    = (NUM_REGS > 2) ? $clog2(NUM_REGS) : 1;
    localparam logic [IDX_W:0] LAST_IDX = (IDX_W + 1)'(NUM_REGS - 1);

    function automatic logic addr_in_range(input logic [31:0] addr);
        logic [IDX_W:0] idx;
        idx = {1'b0, addr[IDX_W+1:2]};
        return ((addr >> (IDX_W + 2)) == 32'h0000_0000) && (idx <= LAST_IDX);
    endfunction

    function automatic logic addr_writable(input logic [31:0] addr);
        logic [IDX_W:0] idx;
        idx = {1'b0, addr[IDX_W+1:2]};
        return addr_in_range(addr) && (idx < LAST_IDX);
    endfunction

    w_state_t         w_state_r, w_state_n;
    r_state_t         r_state_r, r_state_n;
    logic             aw_done_r, aw_done_n, w_done_r, w_done_n;
    logic             awready_r, awready_n, wready_r, wready_n;
    logic             bvalid_r, bvalid_n, arready_r, arready_n, rvalid_r, rvalid_n;
    logic [1:0]       bresp_r, bresp_n, rresp_r, rresp_n;
    logic [IDX_W-1:0] aw_idx_r;
    logic             aw_ok_r;
    logic [31:0]      wdata_r;
    logic [3:0]       wstrb_r;
    logic             aw_hs_s, w_hs_s, ar_hs_s, commit_s;
    logic             aw_have_s, w_have_s, cur_ok_s;
    logic [IDX_W-1:0] cur_idx_s;
    logic [31:0]      cur_wdata_s;
    logic [3:0]       cur_wstrb_s;
    logic             unused_prot_s;

    assign unused_prot_s = ^{awprot, arprot};

    assign aw_hs_s   = awvalid && awready_r;
    assign w_hs_s    = wvalid && wready_r;
    assign ar_hs_s   = arvalid && arready_r;
    assign aw_have_s = aw_done_r || aw_hs_s;
    assign w_have_s  = w_done_r || w_hs_s;

    // A payload arriving on the commit edge bypasses its latch.
    assign cur_idx_s   = aw_hs_s ? awaddr[IDX_W+1:2] : aw_idx_r;
    assign cur_ok_s    = aw_hs_s ? addr_writable(awaddr) : aw_ok_r;
    assign cur_wdata_s = w_hs_s ? wdata : wdata_r;
    assign cur_wstrb_s = w_hs_s ? wstrb : wstrb_r;

    // Write FSM next state, handshake flags and registered outputs.
    always_comb begin
        w_state_n = w_state_r;
        aw_done_n = aw_done_r;
        w_done_n  = w_done_r;
        commit_s  = 1'b0;
        case (w_state_r)
            W_IDLE: begin
                if (aw_have_s && w_have_s) begin
                    commit_s  = 1'b1;
                    w_state_n = W_RESP;
                    aw_done_n = 1'b1;
                    w_done_n  = 1'b1;
                end else begin
                    aw_done_n = aw_have_s;
                    w_done_n  = w_have_s;
                end
            end
            W_RESP: begin
                if (bready) begin
                    w_state_n = W_IDLE;
                    aw_done_n = 1'b0;
                    w_done_n  = 1'b0;
                end else begin
                    w_state_n = W_RESP;
                end
            end
            default: begin
                w_state_n = W_IDLE;
                aw_done_n = 1'b0;
                w_done_n  = 1'b0;
            end
        endcase
        awready_n = (w_state_n == W_IDLE) && !aw_done_n;
        wready_n  = (w_state_n == W_IDLE) && !w_done_n;
        bvalid_n  = (w_state_n == W_RESP);
        if (commit_s) begin
            bresp_n = cur_ok_s ? RESP_OKAY : RESP_SLVERR;
        end else begin
            bresp_n = bresp_r;
        end
    end

    // Read FSM next state and registered outputs.
    always_comb begin
        r_state_n = r_state_r;
        case (r_state_r)
            R_IDLE: begin
                if (ar_hs_s) begin
                    r_state_n = R_DATA;
                end else begin
                    r_state_n = R_IDLE;
                end
            end
            R_DATA: begin
                if (rready) begin
                    r_state_n = R_IDLE;
                end else begin
                    r_state_n = R_DATA;
                end
            end
            default: r_state_n = R_IDLE;
        endcase
        arready_n = (r_state_n == R_IDLE);
        rvalid_n  = (r_state_n == R_DATA);
        if (ar_hs_s) begin
            rresp_n = addr_in_range(araddr) ? RESP_OKAY : RESP_SLVERR;
        end else begin
            rresp_n = rresp_r;
        end
    end

    // State and handshake output registers for both channels.
    always_ff @(posedge aclk) begin
        if (areset) begin
            w_state_r <= W_IDLE;
            r_state_r <= R_IDLE;
            aw_done_r <= 1'b0;
            w_done_r  <= 1'b0;
            awready_r <= 1'b1;
            wready_r  <= 1'b1;
            bvalid_r  <= 1'b0;
            bresp_r   <= RESP_OKAY;
            arready_r <= 1'b1;
            rvalid_r  <= 1'b0;
            rresp_r   <= RESP_OKAY;
        end else begin
            w_state_r <= w_state_n;
            r_state_r <= r_state_n;
            aw_done_r <= aw_done_n;
            w_done_r  <= w_done_n;
            awready_r <= awready_n;
            wready_r  <= wready_n;
            bvalid_r  <= bvalid_n;
            bresp_r   <= bresp_n;
            arready_r <= arready_n;
            rvalid_r  <= rvalid_n;
            rresp_r   <= rresp_n;
        end
    end

    // Payload latches for whichever of AW/W arrives first.
    always_ff @(posedge aclk) begin
        if (areset) begin
            aw_idx_r <= {IDX_W{1'b0}};
            aw_ok_r  <= 1'b0;
            wdata_r  <= 32'h0000_0000;
            wstrb_r  <= 4'b0000;
        end else begin
            if (aw_hs_s) begin
                aw_idx_r <= awaddr[IDX_W+1:2];
                aw_ok_r  <= addr_writable(awaddr);
            end
            if (w_hs_s) begin
                wdata_r <= wdata;
                wstrb_r <= wstrb;
            end
        end
    end

    axi4_lite_reg_bank #(
        .NUM_REGS (NUM_REGS),
        .ID_VALUE (ID_VALUE),
        .IDX_W    (IDX_W)
    ) u_reg_bank (
        .clk      (aclk),
        .reset    (areset),
        .we       (commit_s && cur_ok_s),
        .waddr    (cur_idx_s),
        .wdata    (cur_wdata_s),
        .wstrb    (cur_wstrb_s),
        .re       (ar_hs_s),
        .raddr_ok (addr_in_range(araddr)),
        .raddr    (araddr[IDX_W+1:2]),
        .rdata    (rdata)
    );

    assign awready = awready_r;
    assign wready  = wready_r;
    assign bvalid  = bvalid_r;
    assign bresp   = bresp_r;
    assign arready = arready_r;
    assign rvalid  = rvalid_r;
    assign rresp   = rresp_r;

endmodule

// File: tb/tb_axi4_lite_register_file.sv
// Scoreboard bench for axi4_lite_register_file: a register model pushes the
// expected B/R results as stimulus is driven; each test pops and compares.
module tb_axi4_lite_register_file;

    localparam logic [31:0] ID = 32'hA11E_0001;

    logic        aclk = 1'b0;
    logic        areset;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [2:0]  awprot, arprot;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;

    int          checks = 0;
    int          failures = 0;
    logic [1:0]  exp_b_q [$];
    logic [33:0] exp_r_q [$];
    logic [31:0] model [16];
    logic [1:0]  b_obs, b_exp;
    logic [33:0] r_obs, r_exp;

    axi4_lite_register_file #(.NUM_REGS(16), .ID_VALUE(32'hA11E_0001)) dut (
        .aclk(aclk), .areset(areset),
        .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
    );

    always #5 aclk = ~aclk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        if (a[31:6] == 26'd0 && a[5:2] != 4'd15) begin
            for (int b = 0; b < 4; b++) begin
                if (s[b]) model[a[5:2]][8*b +: 8] = d[8*b +: 8];
            end
            exp_b_q.push_back(2'b00);
        end else begin
            exp_b_q.push_back(2'b10);
        end
    endtask

    task automatic model_read(input logic [31:0] a);
        if (a[31:6] != 26'd0) exp_r_q.push_back({2'b10, 32'h0});
        else if (a[5:2] == 4'd15) exp_r_q.push_back({2'b00, ID});
        else exp_r_q.push_back({2'b00, model[a[5:2]]});
    endtask

    task automatic do_reset();
        areset = 1'b1;
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0; bready = 1'b0; rready = 1'b0;
        tick();
        tick();
        areset = 1'b0;
        for (int i = 0; i < 16; i++) model[i] = 32'h0;
    endtask

    task automatic send_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                              input int aw_dly, input int w_dly);
        model_write(a, d, s);
        fork
            begin
                logic hs;
                repeat (aw_dly) tick();
                awaddr = a; awprot = 3'b000; awvalid = 1'b1;
                for (int i = 0; i < 50; i++) begin
                    hs = awready;
                    tick();
                    if (hs) break;
                end
                awvalid = 1'b0;
            end
            begin
                logic hs;
                repeat (w_dly) tick();
                wdata = d; wstrb = s; wvalid = 1'b1;
                for (int i = 0; i < 50; i++) begin
                    hs = wready;
                    tick();
                    if (hs) break;
                end
                wvalid = 1'b0;
            end
        join
    endtask

    task automatic get_b(output logic [1:0] obs);
        obs = 2'bxx;
        bready = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (bvalid) begin
                obs = bresp;
                tick();
                break;
            end
            tick();
        end
        bready = 1'b0;
    endtask

    task automatic send_read(input logic [31:0] a);
        logic hs;
        model_read(a);
        araddr = a; arprot = 3'b000; arvalid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            hs = arready;
            tick();
            if (hs) break;
        end
        arvalid = 1'b0;
    endtask

    task automatic get_r(output logic [33:0] obs);
        obs = 34'hx;
        rready = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (rvalid) begin
                obs = {rresp, rdata};
                tick();
                break;
            end
            tick();
        end
        rready = 1'b0;
    endtask

    task automatic test_reset();
        logic [40:0] obs, exp;
        do_reset();
        obs = {awready, wready, arready, bvalid, rvalid, bresp, rresp, rdata};
        exp = {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 32'h0};
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL reset_outputs: got %h expected %h", obs, exp);
        end
        send_read(32'h0000_0014);
        get_r(r_obs); r_exp = exp_r_q.pop_front(); checks++;
        if (r_obs !== r_exp) begin
            failures++;
            $display("FAIL reset_reg_read: got %h expected %h", r_obs, r_exp);
        end
    endtask

    task automatic test_same_cycle();
        send_write(32'h0000_0004, 32'hDEAD_BEEF, 4'hF, 0, 0);
        checks++;
        if (bvalid !== 1'b1) begin
            failures++;
            $display("FAIL b_latency: bvalid got %b expected 1", bvalid);
        end
        get_b(b_obs); b_exp = exp_b_q.pop_front(); checks++;
        if (b_obs !== b_exp) begin
            failures++;
            $display("FAIL same_cycle_bresp: got %b expected %b", b_obs, b_exp);
        end
        send_read(32'h0000_0004);
        checks++;
        if (rvalid !== 1'b1) begin
            failures++;
            $display("FAIL r_latency: rvalid got %b expected 1", rvalid);
        end
        get_r(r_obs); r_exp = exp_r_q.pop_front(); checks++;
        if (r_obs !== r_exp) begin
            failures++;
            $display("FAIL same_cycle_read: got %h expected %h", r_obs, r_exp);
        end
    endtask

    task automatic test_w_first();
        send_write(32'h0000_0008, 32'h1122_3344, 4'b0101, 2, 0);
        get_b(b_obs); b_exp = exp_b_q.pop_front(); checks++;
        if (b_obs !== b_exp) begin
            failures++;
            $display("FAIL w_first_bresp: got %b expected %b", b_obs, b_exp);
        end
        send_read(32'h0000_0008);
        get_r(r_obs); r_exp = exp_r_q.pop_front(); checks++;
        if (r_obs !== r_exp) begin
            failures++;
            $display("FAIL w_first_strobe_read: got %h expected %h", r_obs, r_exp);
        end
    endtask

    task automatic test_id_and_range();
        logic [31:0] addrs [3];
        logic [3:0]  strbs [3];
        addrs = '{32'h0000_003C, 32'h0000_0040, 32'h0000_0004};
        strbs = '{4'hF, 4'hF, 4'h0};
        for (int i = 0; i < 3; i++) begin
            send_write(addrs[i], 32'hFFFF_FFFF, strbs[i], 0, 1);
            get_b(b_obs); b_exp = exp_b_q.pop_front(); checks++;
            if (b_obs !== b_exp) begin
                failures++;
                $display("FAIL range_bresp[%0d]: got %b expected %b", i, b_obs, b_exp);
            end
        end
        addrs = '{32'h0000_003C, 32'h0000_0040, 32'h0000_0006};
        for (int i = 0; i < 3; i++) begin
            send_read(addrs[i]);
            get_r(r_obs); r_exp = exp_r_q.pop_front(); checks++;
            if (r_obs !== r_exp) begin
                failures++;
                $display("FAIL range_read[%0d]: got %h expected %h", i, r_obs, r_exp);
            end
        end
    endtask

    task automatic test_b_backpressure();
        send_write(32'h0000_000C, 32'hA5A5_0003, 4'hF, 0, 0);
        model_write(32'h0000_0010, 32'h0000_B00B, 4'hF);
        awaddr = 32'h0000_0010; awvalid = 1'b1;
        wdata = 32'h0000_B00B; wstrb = 4'hF; wvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({bvalid, bresp, awready, wready} !== {1'b1, 2'b00, 1'b0, 1'b0}) begin
                failures++;
                $display("FAIL backpressure_hold[%0d]: got %b expected 10000",
                         i, {bvalid, bresp, awready, wready});
            end
            tick();
        end
        b_exp = exp_b_q.pop_front(); checks++;
        if (bresp !== b_exp) begin
            failures++;
            $display("FAIL backpressure_bresp: got %b expected %b", bresp, b_exp);
        end
        bready = 1'b1;
        tick();
        bready = 1'b0;
        checks++;
        if ({bvalid, awready, wready} !== 3'b011) begin
            failures++;
            $display("FAIL backpressure_release: got %b expected 011", {bvalid, awready, wready});
        end
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        checks++;
        if (bvalid !== 1'b1) begin
            failures++;
            $display("FAIL second_write_commit: bvalid got %b expected 1", bvalid);
        end
        get_b(b_obs); b_exp = exp_b_q.pop_front(); checks++;
        if (b_obs !== b_exp) begin
            failures++;
            $display("FAIL second_write_bresp: got %b expected %b", b_obs, b_exp);
        end
        send_read(32'h0000_000C);
        get_r(r_obs); r_exp = exp_r_q.pop_front(); checks++;
        if (r_obs !== r_exp) begin
            failures++;
            $display("FAIL backpressure_first_data: got %h expected %h", r_obs, r_exp);
        end
        send_read(32'h0000_0010);
        get_r(r_obs); r_exp = exp_r_q.pop_front(); checks++;
        if (r_obs !== r_exp) begin
            failures++;
            $display("FAIL backpressure_second_data: got %h expected %h", r_obs, r_exp);
        end
    endtask

    task automatic test_concurrent_rw();
        send_write(32'h0000_0008, 32'h0000_0005, 4'hF, 0, 0);
        get_b(b_obs); b_exp = exp_b_q.pop_front(); checks++;
        if (b_obs !== b_exp) begin
            failures++;
            $display("FAIL concurrent_setup_bresp: got %b expected %b", b_obs, b_exp);
        end
        model_read(32'h0000_0008);
        model_write(32'h0000_0008, 32'h0000_0009, 4'hF);
        awaddr = 32'h0000_0008; awvalid = 1'b1;
        wdata = 32'h0000_0009; wstrb = 4'hF; wvalid = 1'b1;
        araddr = 32'h0000_0008; arvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        get_r(r_obs); r_exp = exp_r_q.pop_front(); checks++;
        if (r_obs !== r_exp) begin
            failures++;
            $display("FAIL concurrent_old_value: got %h expected %h", r_obs, r_exp);
        end
        get_b(b_obs); b_exp = exp_b_q.pop_front(); checks++;
        if (b_obs !== b_exp) begin
            failures++;
            $display("FAIL concurrent_bresp: got %b expected %b", b_obs, b_exp);
        end
        send_read(32'h0000_0008);
        get_r(r_obs); r_exp = exp_r_q.pop_front(); checks++;
        if (r_obs !== r_exp) begin
            failures++;
            $display("FAIL concurrent_new_value: got %h expected %h", r_obs, r_exp);
        end
    endtask

    task automatic test_reset_midflight();
        wdata = 32'hFFFF_FFFF; wstrb = 4'hF; wvalid = 1'b1;
        tick();
        wvalid = 1'b0;
        checks++;
        if ({awready, wready} !== 2'b10) begin
            failures++;
            $display("FAIL w_latched_readies: got %b expected 10", {awready, wready});
        end
        awaddr = 32'h0000_000C; awvalid = 1'b1; areset = 1'b1;
        tick();
        areset = 1'b0; awvalid = 1'b0;
        for (int i = 0; i < 16; i++) model[i] = 32'h0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({awready, wready, arready, bvalid} !== 4'b1110) begin
                failures++;
                $display("FAIL midflight_reset_state[%0d]: got %b expected 1110",
                         i, {awready, wready, arready, bvalid});
            end
            tick();
        end
        send_read(32'h0000_000C);
        get_r(r_obs); r_exp = exp_r_q.pop_front(); checks++;
        if (r_obs !== r_exp) begin
            failures++;
            $display("FAIL midflight_target: got %h expected %h", r_obs, r_exp);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a;
        for (int n = 0; n < 12; n++) begin
            a = ($urandom_range(0, 17) << 2) | $urandom_range(0, 3);
            send_write(a, $urandom, 4'($urandom_range(0, 15)),
                       $urandom_range(0, 2), $urandom_range(0, 2));
            get_b(b_obs); b_exp = exp_b_q.pop_front(); checks++;
            if (b_obs !== b_exp) begin
                failures++;
                $display("FAIL b2b_bresp[%0d] addr %h: got %b expected %b", n, a, b_obs, b_exp);
            end
        end
        for (int k = 0; k < 18; k++) begin
            a = 32'(k) << 2;
            send_read(a);
            get_r(r_obs); r_exp = exp_r_q.pop_front(); checks++;
            if (r_obs !== r_exp) begin
                failures++;
                $display("FAIL b2b_read[%0d]: got %h expected %h", k, r_obs, r_exp);
            end
        end
    endtask

    initial begin
        awaddr = 32'h0; awprot = 3'b000; awvalid = 1'b0;
        wdata = 32'h0; wstrb = 4'h0; wvalid = 1'b0; bready = 1'b0;
        araddr = 32'h0; arprot = 3'b000; arvalid = 1'b0; rready = 1'b0;
        areset = 1'b1;
        test_reset();
        test_same_cycle();
        test_w_first();
        test_id_and_range();
        test_b_backpressure();
        test_concurrent_rw();
        test_reset_midflight();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
